// File: rtl/trap_ctrl.sv
// Trap requester: synchronises machine irqs, prioritises exceptions over interrupts and
// hands one trap at a time to pipeline control. Build with TRAP_VECTORED_EN for vectored irqs.
module trap_ctrl #(
    parameter int IRQ_SYNC_STAGES = 2   // legal range 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie_bits,
    input  logic [31:0] mtvec,
    input  logic [31:0] int_pc,
    input  logic        trap_insert,
    output logic        trap_req,
    output logic [31:0] trap_addr,
    output logic        trap_commit,
    output logic [31:0] trap_mepc,
    output logic [31:0] trap_mcause,
    output logic [31:0] trap_mtval,
    output logic [2:0]  irq_pending
);

    // state  | meaning
    // IDLE   | no trap outstanding, evaluating exceptions and enabled irqs
    // REQ    | trap latched, trap_req held until trap_insert
    // COMMIT | one-cycle trap_commit with CSR write data
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  irq_sync [IRQ_SYNC_STAGES];
    logic [2:0]  irq_en;
    logic [3:0]  irq_code;
    logic [31:0] base_addr;
    logic [31:0] irq_addr;
    logic        lat_irq;
    logic [3:0]  lat_code;
    logic [31:0] lat_tval;
    logic [31:0] lat_pc;

    // bit order {MEIP, MTIP, MSIP}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IRQ_SYNC_STAGES; i++) irq_sync[i] <= 3'b000;
        end else begin
            irq_sync[0] <= {irq_ext, irq_timer, irq_sw};
            for (int i = 1; i < IRQ_SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
        end
    end

    assign irq_pending = irq_sync[IRQ_SYNC_STAGES-1];
    assign irq_en      = irq_pending & mie_bits & {3{mstatus_mie}};

    always_comb begin
        irq_code = 4'd0;
        if (irq_en[2])      irq_code = 4'd11;
        else if (irq_en[0]) irq_code = 4'd3;
        else if (irq_en[1]) irq_code = 4'd7;
    end

    assign base_addr = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // reserved modes 2/3 fall back to direct
    assign irq_addr = (mtvec[1:0] == 2'b01) ? base_addr + {26'b0, irq_code, 2'b00} : base_addr;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec[1:0];
    assign irq_addr = base_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            trap_req    <= 1'b0;
            trap_addr   <= 32'd0;
            trap_commit <= 1'b0;
            trap_mepc   <= 32'd0;
            trap_mcause <= 32'd0;
            trap_mtval  <= 32'd0;
            lat_irq     <= 1'b0;
            lat_code    <= 4'd0;
            lat_tval    <= 32'd0;
            lat_pc      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        state     <= REQ;
                        trap_req  <= 1'b1;
                        trap_addr <= base_addr;
                        lat_irq   <= 1'b0;
                        lat_code  <= exc_cause;
                        lat_tval  <= exc_tval;
                        lat_pc    <= exc_pc;
                    end else if (|irq_en) begin
                        state     <= REQ;
                        trap_req  <= 1'b1;
                        trap_addr <= irq_addr;
                        lat_irq   <= 1'b1;
                        lat_code  <= irq_code;
                        lat_tval  <= 32'd0;
                        lat_pc    <= exc_pc;
                    end
                end
                REQ: begin
                    if (trap_insert) begin
                        state       <= COMMIT;
                        trap_req    <= 1'b0;
                        trap_commit <= 1'b1;
                        trap_mepc   <= lat_irq ? int_pc : lat_pc;
                        trap_mcause <= {lat_irq, 27'b0, lat_code};
                        trap_mtval  <= lat_tval;
                    end else if (exc_valid && lat_irq) begin
                        // an exception from exec is older than the pending interrupt
                        trap_addr <= base_addr;
                        lat_irq   <= 1'b0;
                        lat_code  <= exc_cause;
                        lat_tval  <= exc_tval;
                        lat_pc    <= exc_pc;
                    end
                end
                COMMIT: begin
                    state       <= IDLE;
                    trap_commit <= 1'b0;
                    trap_mepc   <= 32'd0;
                    trap_mcause <= 32'd0;
                    trap_mtval  <= 32'd0;
                end
                default: begin
                    state    <= IDLE;
                    trap_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
